reg_dump_reader: RTL and testbench

//   Multi-cycle read-out engine for the CPU register file: on a start pulse it walks an

---
 rtl/reg_dump_reader_pkg.sv | 11 +
 rtl/reg_dump_reader_if.sv | 30 +++
 rtl/reg_dump_addr_ctr.sv | 34 +++
 rtl/reg_dump_reader.sv | 81 ++++++++
 tb/tb_reg_dump_reader.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/reg_dump_reader_pkg.sv
// reg_dump_reader_pkg: default widths and FSM state encoding for the register dump reader
package reg_dump_reader_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    typedef enum logic [1:0] {
        RDR_IDLE    = 2'd0,
        RDR_READ    = 2'd1,
        RDR_PRESENT = 2'd2,
        RDR_DONE    = 2'd3
    } rdr_state_e;
endpackage

// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if: dump control, register-file read port and beat stream of the dump reader
interface reg_dump_reader_if
    import reg_dump_reader_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int AW = DEF_ADDR_WIDTH
) ();
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic          abort;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          range_err;
    modport slave (
        input  start, first_addr, last_addr, abort, rf_rdata, out_ready,
        output rf_raddr, out_valid, out_addr, out_data, out_last, busy, done, range_err
    );
    modport master (
        output start, first_addr, last_addr, abort, rf_rdata, out_ready,
        input  rf_raddr, out_valid, out_addr, out_data, out_last, busy, done, range_err
    );
endinterface

// File: rtl/reg_dump_addr_ctr.sv
// reg_dump_addr_ctr: walk pointer and latched end address of the current dump range
module reg_dump_addr_ctr
    import reg_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  is_last
);
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, last_q, last_d;

    always_comb begin
        ptr_d   = load ? first_addr : inc ? ptr_q + 1'b1 : ptr_q;
        last_d  = load ? last_addr : last_q;
        ptr     = ptr_q;
        is_last = ptr_q == last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q  <= '0;
            last_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks an inclusive register range and streams (addr, data) beats over valid/ready
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic              clk,
    input logic              rst,
    reg_dump_reader_if.slave bus
);
    rdr_state_e            state_q, state_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  done_q, done_d, range_err_q, range_err_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d, ptr;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  load, inc, is_last, cut, accept, capture, idle;

    reg_dump_addr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .inc        (inc),
        .first_addr (bus.first_addr),
        .last_addr  (bus.last_addr),
        .ptr        (ptr),
        .is_last    (is_last)
    );

    always_comb begin
        idle        = state_q == RDR_IDLE;
        cut         = bus.abort && !idle;
        accept      = state_q == RDR_PRESENT && bus.out_ready && !cut;
        capture     = state_q == RDR_READ && !cut;
        load        = idle && bus.start && bus.last_addr >= bus.first_addr;
        range_err_d = idle && bus.start && bus.last_addr < bus.first_addr;
        inc         = accept && !out_last_q;
        done_d      = accept && out_last_q;
        state_d     = state_q;
        unique case (state_q)
            RDR_IDLE:    state_d = load ? RDR_READ : RDR_IDLE;
            RDR_READ:    state_d = RDR_PRESENT;
            RDR_PRESENT: state_d = !bus.out_ready ? RDR_PRESENT : out_last_q ? RDR_DONE : RDR_READ;
            default:     state_d = RDR_IDLE;
        endcase
        if (cut) state_d = RDR_IDLE;
        // Beat fields freeze at capture so later register writes cannot leak into a stalled beat
        out_valid_d   = capture || (state_q == RDR_PRESENT && !bus.out_ready && !cut);
        out_addr_d    = capture ? ptr : out_addr_q;
        out_data_d    = capture ? bus.rf_rdata : out_data_q;
        out_last_d    = capture ? is_last : out_last_q;
        bus.rf_raddr  = idle ? '0 : ptr;
        bus.out_valid = out_valid_q;
        bus.out_addr  = out_addr_q;
        bus.out_data  = out_data_q;
        bus.out_last  = out_last_q;
        bus.busy      = !idle;
        bus.done      = done_q;
        bus.range_err = range_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RDR_IDLE;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed and randomized dumps against a snapshot model of the register file
module tb_reg_dump_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rf [32];
    int          n_cmp = 0;
    int          n_bad = 0;

    reg_dump_reader_if bus ();
    reg_dump_reader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    assign bus.rf_rdata = rf[bus.rf_raddr];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats come from a snapshot of the register file taken when the dump is requested.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall_pct,
                            input int hold_beat, input int cut_beat, input bit cut_rst,
                            input bit spam, input bit abort_with_start);
        logic [31:0] snap [32];
        int n_exp, beats, cyc, busy_cyc, stalls, dones, acc_cyc, held;
        bit seen;
        snap = rf;
        n_exp = int'(l) - int'(f) + 1;
        beats = 0; cyc = 1; busy_cyc = 0; stalls = 0; dones = 0; acc_cyc = -10; held = 0; seen = 0;
        bus.first_addr = f; bus.last_addr = l; bus.start = 1'b1;
        bus.abort = abort_with_start; bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        while (bus.busy && cyc < 400) begin
            busy_cyc++;
            if (bus.done) begin
                dones++;
                chk("done_timing", cyc, acc_cyc + 1);
            end
            if (bus.out_valid) begin
                if (!seen) chk("first_valid_latency", cyc, 2);
                seen = 1;
                chk("beat_addr", bus.out_addr, f + beats);
                chk("beat_data", bus.out_data, snap[f + beats]);
                chk("beat_last", bus.out_last, beats == n_exp - 1);
            end
            if (cut_beat == beats && bus.out_valid) begin
                if (cut_rst) rst = 1'b0; else bus.abort = 1'b1;
                bus.out_ready = 1'($urandom);
                tick();
                rst = 1'b1; bus.abort = 1'b0; bus.out_ready = 1'b0;
                chk("cut_valid", bus.out_valid, 0);
                chk("cut_busy", bus.busy, 0);
                if (cut_rst) chk("rst_out_data", bus.out_data, 0);
                repeat (4) begin
                    tick();
                    chk("cut_no_done", bus.done, 0);
                end
                return;
            end
            if (beats == hold_beat && bus.out_valid && held < 5) begin
                bus.out_ready = 1'b0;
                held++;
                if (bus.out_addr != 0) rf[bus.out_addr] = 32'h99 + held;
            end else begin
                bus.out_ready = $urandom_range(99) >= stall_pct;
            end
            bus.start = spam && (cyc % 3 == 0);
            if (spam) begin
                bus.first_addr = 5'($urandom);
                bus.last_addr = 5'($urandom);
            end
            if (bus.out_valid && !bus.out_ready) stalls++;
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                acc_cyc = cyc;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0; bus.out_ready = 1'b0;
        chk("dump_finished", cyc < 400, 1);
        chk("beat_count", beats, n_exp);
        chk("done_pulses", dones, 1);
        chk("busy_cycles", busy_cyc, 2 * n_exp + 1 + stalls);
        chk("idle_valid", bus.out_valid, 0);
    endtask

    initial begin
        logic [4:0] f, l, t;
        int cb;
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
        bus.first_addr = '0; bus.last_addr = '0;
        foreach (rf[i]) rf[i] = (i == 0) ? 32'h0 : $urandom;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_range_err", bus.range_err, 0);
        chk("rst_raddr", bus.rf_raddr, 0);
        chk("rst_out", {bus.out_addr, bus.out_data, bus.out_last}, 0);
        rst = 1'b1;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort_busy", bus.busy, 0);
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        run_dump(1, 3, 0, -1, -1, 0, 0, 0);
        run_dump(0, 31, 0, -1, -1, 0, 0, 0);
        run_dump(1, 3, 0, 1, -1, 0, 0, 0);
        chk("stall_write_landed", rf[2], 32'h99 + 5);
        rf[2] = 32'h22;
        bus.first_addr = 5'd7; bus.last_addr = 5'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("range_err_pulse", bus.range_err, 1);
        chk("range_err_busy", bus.busy, 0);
        chk("range_err_valid", bus.out_valid, 0);
        tick();
        chk("range_err_single", bus.range_err, 0);
        chk("range_err_idle", bus.busy, 0);
        run_dump(1, 3, 0, -1, 1, 0, 0, 0);
        run_dump(1, 3, 0, -1, 1, 1, 0, 0);
        run_dump(1, 3, 0, -1, -1, 0, 0, 0);
        run_dump(1, 3, 0, -1, -1, 0, 1, 0);
        run_dump(2, 9, 0, -1, -1, 0, 0, 1);
        run_dump(31, 31, 0, -1, -1, 0, 0, 0);
        run_dump(0, 0, 30, -1, -1, 0, 0, 0);
        repeat (12) begin
            f = 5'($urandom);
            l = 5'($urandom);
            if (f > l) begin
                t = f; f = l; l = t;
            end
            cb = ($urandom_range(4) == 0) ? int'($urandom_range(int'(l - f))) : -1;
            run_dump(f, l, $urandom_range(50), $urandom_range(3) == 0 ? 0 : -1, cb,
                     1'($urandom), 1'($urandom), 1'b0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
